// File: rtl/axis_tpg_checker.sv
// AXI-Stream test-pattern sink: tracks x/y/frame position, recomputes the expected pixel and counts framing/data errors.
// Optional upstream backpressure is enabled by defining AXIS_TPG_CHK_THROTTLE_EN.
module axis_tpg_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int CHESS_WPOW = 4,
    parameter int CHESS_HPOW = 4
) (
    input  logic                  m_axis_aclk,
    input  logic                  rst_n,
    input  logic [15:0]           ACTIVE_WIDTH,
    input  logic [15:0]           ACTIVE_HEIGHT,
    input  logic [3:0]            tpg_mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  clr_err,
    output logic                  locked,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_data_cnt,
    output logic [15:0]           err_sof_cnt,
    output logic [15:0]           err_eol_cnt,
    output logic                  err_any
);

    typedef enum logic {ST_HUNT, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [15:0] w_q, w_d, h_q, h_d;
    logic [3:0]  mode_q, mode_d;
    logic        rdy_q, rdy_d;
    logic        pend_data_q, pend_data_d;
    logic        pend_sof_q, pend_sof_d;
    logic        pend_eol_q, pend_eol_d;
    logic        pend_frame_q, pend_frame_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] err_data_cnt_q, err_data_cnt_d;
    logic [15:0] err_sof_cnt_q, err_sof_cnt_d;
    logic [15:0] err_eol_cnt_q, err_eol_cnt_d;
    logic        err_any_q, err_any_d;

    logic                  beat;
    logic [3:0]            chk_mode;
    logic [15:0]           exp_val;
    logic                  exp_ones;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [15:0]           z_seed;
    logic                  at_origin, at_eol, at_last_line;

`ifdef AXIS_TPG_CHK_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign s_axis_tready = rdy_q & (lfsr_q[0] | lfsr_q[1]);
`else
    assign s_axis_tready = rdy_q;
`endif

    assign beat = s_axis_tvalid & s_axis_tready;

    // A SOF beat starts a new frame, so it is checked against the newly presented mode.
    assign chk_mode = s_axis_tuser ? tpg_mode : mode_q;

    always_comb begin
        exp_val  = 16'd0;
        exp_ones = 1'b0;
        case (chk_mode)
            4'd0:    exp_ones = (x_q[CHESS_WPOW] == y_q[CHESS_HPOW]);
            4'd1:    exp_val  = x_q;
            4'd2:    exp_val  = y_q;
            4'd3:    exp_val  = x_q + z_q;
            4'd4:    exp_val  = y_q + z_q;
            4'd5:    exp_ones = 1'b1;
            default: exp_val  = 16'd0;
        endcase
        exp_data = exp_ones ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(exp_val);
    end

    assign z_seed       = (tpg_mode == 4'd3 || tpg_mode == 4'd4) ? 16'(s_axis_tdata) : 16'd0;
    assign at_origin    = (x_q == 16'd0) && (y_q == 16'd0);
    assign at_eol       = (x_q == w_q - 16'd1);
    assign at_last_line = (y_q == h_q - 16'd1);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        w_d          = w_q;
        h_d          = h_q;
        mode_d       = mode_q;
        rdy_d        = 1'b1;
        pend_data_d  = 1'b0;
        pend_sof_d   = 1'b0;
        pend_eol_d   = 1'b0;
        pend_frame_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (beat && s_axis_tuser) begin
                    w_d     = ACTIVE_WIDTH;
                    h_d     = ACTIVE_HEIGHT;
                    mode_d  = tpg_mode;
                    z_d     = z_seed;
                    x_d     = 16'd1;
                    y_d     = 16'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (beat) begin
                    pend_sof_d = (s_axis_tuser != at_origin);
                    pend_eol_d = (s_axis_tlast != at_eol);
                    if (s_axis_tuser && !at_origin) begin
                        // Resynchronise: this beat becomes (0,0) of a fresh frame.
                        w_d    = ACTIVE_WIDTH;
                        h_d    = ACTIVE_HEIGHT;
                        mode_d = tpg_mode;
                        z_d    = z_seed;
                        x_d    = 16'd1;
                        y_d    = 16'd0;
                    end else begin
                        pend_data_d = (s_axis_tdata != exp_data);
                        if (s_axis_tuser) begin
                            w_d    = ACTIVE_WIDTH;
                            h_d    = ACTIVE_HEIGHT;
                            mode_d = tpg_mode;
                        end
                        if (s_axis_tlast || at_eol) begin
                            x_d = 16'd0;
                            if (at_last_line) begin
                                y_d          = 16'd0;
                                z_d          = z_q + 16'd1;
                                pend_frame_d = at_eol;
                            end else begin
                                y_d = y_q + 16'd1;
                            end
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                end
            end
        endcase
    end

    // Counters consume the compare result registered on the previous edge.
    always_comb begin
        frame_cnt_d    = frame_cnt_q + {15'd0, pend_frame_q};
        frame_done_d   = pend_frame_q;
        err_data_cnt_d = err_data_cnt_q;
        err_sof_cnt_d  = err_sof_cnt_q;
        err_eol_cnt_d  = err_eol_cnt_q;
        err_any_d      = err_any_q | pend_data_q | pend_sof_q | pend_eol_q;
        if (pend_data_q && err_data_cnt_q != 16'hFFFF) err_data_cnt_d = err_data_cnt_q + 16'd1;
        if (pend_sof_q && err_sof_cnt_q != 16'hFFFF)   err_sof_cnt_d  = err_sof_cnt_q + 16'd1;
        if (pend_eol_q && err_eol_cnt_q != 16'hFFFF)   err_eol_cnt_d  = err_eol_cnt_q + 16'd1;
        if (clr_err) begin
            err_data_cnt_d = 16'd0;
            err_sof_cnt_d  = 16'd0;
            err_eol_cnt_d  = 16'd0;
            err_any_d      = 1'b0;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!rst_n) begin
            state_q        <= ST_HUNT;
            x_q            <= 16'd0;
            y_q            <= 16'd0;
            z_q            <= 16'd0;
            w_q            <= 16'd0;
            h_q            <= 16'd0;
            mode_q         <= 4'd0;
            rdy_q          <= 1'b0;
            pend_data_q    <= 1'b0;
            pend_sof_q     <= 1'b0;
            pend_eol_q     <= 1'b0;
            pend_frame_q   <= 1'b0;
            frame_cnt_q    <= 16'd0;
            frame_done_q   <= 1'b0;
            err_data_cnt_q <= 16'd0;
            err_sof_cnt_q  <= 16'd0;
            err_eol_cnt_q  <= 16'd0;
            err_any_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            z_q            <= z_d;
            w_q            <= w_d;
            h_q            <= h_d;
            mode_q         <= mode_d;
            rdy_q          <= rdy_d;
            pend_data_q    <= pend_data_d;
            pend_sof_q     <= pend_sof_d;
            pend_eol_q     <= pend_eol_d;
            pend_frame_q   <= pend_frame_d;
            frame_cnt_q    <= frame_cnt_d;
            frame_done_q   <= frame_done_d;
            err_data_cnt_q <= err_data_cnt_d;
            err_sof_cnt_q  <= err_sof_cnt_d;
            err_eol_cnt_q  <= err_eol_cnt_d;
            err_any_q      <= err_any_d;
        end
    end

    assign locked       = (state_q == ST_RUN);
    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_data_cnt = err_data_cnt_q;
    assign err_sof_cnt  = err_sof_cnt_q;
    assign err_eol_cnt  = err_eol_cnt_q;
    assign err_any      = err_any_q;

endmodule

// File: tb/tb_axis_tpg_checker.sv
// Directed and randomized bench for axis_tpg_checker; the expected pixel comes from a pattern function,
// expected counters from what each scenario deliberately injects.
module tb_axis_tpg_checker;

    localparam int DW = 16;
    localparam int CW = 1;
    localparam int CH = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   active_width, active_height;
    logic [3:0]    tpg_mode;
    logic [DW-1:0] tdata;
    logic          tlast, tuser, tvalid, tready;
    logic          clr_err;
    logic          locked, frame_done, err_any;
    logic [15:0]   frame_cnt, err_data_cnt, err_sof_cnt, err_eol_cnt;

    int total = 0;
    int bad = 0;
    int fd_pulses = 0;
    int fd_base = 0;

    always #5 clk = ~clk;

    axis_tpg_checker #(.DATA_WIDTH(DW), .CHESS_WPOW(CW), .CHESS_HPOW(CH)) dut (
        .m_axis_aclk   (clk),
        .rst_n         (rst_n),
        .ACTIVE_WIDTH  (active_width),
        .ACTIVE_HEIGHT (active_height),
        .tpg_mode      (tpg_mode),
        .s_axis_tdata  (tdata),
        .s_axis_tlast  (tlast),
        .s_axis_tuser  (tuser),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .clr_err       (clr_err),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_data_cnt  (err_data_cnt),
        .err_sof_cnt   (err_sof_cnt),
        .err_eol_cnt   (err_eol_cnt),
        .err_any       (err_any)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_pulses++;

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] pix(input int mode, input int x, input int y, input int z);
        case (mode)
            0:       return (((x >> CW) & 1) == ((y >> CH) & 1)) ? 16'hFFFF : 16'h0000;
            1:       return 16'(x);
            2:       return 16'(y);
            3:       return 16'(x + z);
            4:       return 16'(y + z);
            5:       return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        int guard;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        guard  = 0;
        while (tready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) chk("beat_timeout", {31'd0, tready}, 32'd1);
        @(negedge clk);
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    // One frame from (0,0); fx/fy flips a pixel, ex/ey ends a line early, sx/sy injects a stray SOF (-1 = none).
    task automatic send_frame(input int mode, input int w, input int h, input int z,
                              input int fx, input int fy, input int ex, input int ey,
                              input int sx, input int sy);
        int x, y, n;
        logic [15:0] d;
        logic u, l, sof_done;
        x = 0;
        y = 0;
        n = 0;
        sof_done = 1'b0;
        while (n < 4 * w * h) begin
            n++;
            u = (x == 0 && y == 0);
            l = (x == w - 1);
            d = pix(mode, x, y, z);
            if (x == fx && y == fy) d = ~d;
            if (x == ex && y == ey) l = 1'b1;
            if (!sof_done && x == sx && y == sy) begin
                sof_done = 1'b1;
                send_beat(16'(x + 16'h0100), 1'b1, 1'b0);
                x = 1;
                y = 0;
            end else begin
                send_beat(d, u, l);
                if (l) begin
                    x = 0;
                    if (y == h - 1) break;
                    y++;
                end else begin
                    x++;
                end
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tvalid  = 1'b0;
        tuser   = 1'b0;
        tlast   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fd_base = fd_pulses;
    endtask

    task automatic check_counts(input string pfx, input int frames, input int ed, input int es,
                                input int ee, input logic lk);
        chk({pfx, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(frames));
        chk({pfx, "_frame_done_pulses"}, 32'(fd_pulses - fd_base), 32'(frames));
        chk({pfx, "_err_data"}, {16'd0, err_data_cnt}, 32'(ed));
        chk({pfx, "_err_sof"}, {16'd0, err_sof_cnt}, 32'(es));
        chk({pfx, "_err_eol"}, {16'd0, err_eol_cnt}, 32'(ee));
        chk({pfx, "_err_any"}, {31'd0, err_any}, {31'd0, (ed + es + ee) != 0});
        chk({pfx, "_locked"}, {31'd0, locked}, {31'd0, lk});
    endtask

    initial begin
        int w, h, z, fx, fy;
        int modes[5] = '{2, 4, 5, 6, 7};
        rst_n         = 1'b0;
        tvalid        = 1'b0;
        tuser         = 1'b0;
        tlast         = 1'b0;
        tdata         = '0;
        clr_err       = 1'b0;
        active_width  = 16'd8;
        active_height = 16'd4;
        tpg_mode      = 4'd1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_counts("rst", 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
`ifndef AXIS_TPG_CHK_THROTTLE_EN
        chk("post_rst_tready", {31'd0, tready}, 32'd1);
`endif

        // HUNT discards beats without tuser
        for (int i = 0; i < 5; i++) send_beat(16'($urandom), 1'b0, 1'($urandom));
        settle();
        check_counts("hunt", 0, 0, 0, 0, 1'b0);

        // Mode 1, clean, three frames
        for (int f = 0; f < 3; f++) send_frame(1, 8, 4, 0, -1, -1, -1, -1, -1, -1);
        settle();
        check_counts("ramp_x", 3, 0, 0, 0, 1'b1);

        // Mode 3, z seeded from first SOF tdata
        do_reset();
        tpg_mode = 4'd3;
        send_frame(3, 8, 4, 5, -1, -1, -1, -1, -1, -1);
        send_frame(3, 8, 4, 6, -1, -1, -1, -1, -1, -1);
        settle();
        check_counts("x_frame", 2, 0, 0, 0, 1'b1);

        // Remaining modes, random geometry and seed, one flipped pixel in frame 2
        foreach (modes[i]) begin
            do_reset();
            w = $urandom_range(2, 6);
            h = $urandom_range(2, 4);
            z = $urandom_range(0, 65535);
            fx = $urandom_range(1, w - 1);
            fy = $urandom_range(0, h - 1);
            active_width  = 16'(w);
            active_height = 16'(h);
            tpg_mode      = 4'(modes[i]);
            send_frame(modes[i], w, h, z, -1, -1, -1, -1, -1, -1);
            send_frame(modes[i], w, h, z + 1, fx, fy, -1, -1, -1, -1);
            settle();
            check_counts($sformatf("mode%0d", modes[i]), 2, 1, 0, 0, 1'b1);
        end

        // Chess, 4x4, flipped pixel at (2,0)
        do_reset();
        active_width  = 16'd4;
        active_height = 16'd4;
        tpg_mode      = 4'd0;
        send_frame(0, 4, 4, 0, 2, 0, -1, -1, -1, -1);
        settle();
        check_counts("chess_flip", 1, 1, 0, 0, 1'b1);

        // Early tlast at (5,1)
        do_reset();
        active_width  = 16'd8;
        active_height = 16'd4;
        tpg_mode      = 4'd1;
        send_frame(1, 8, 4, 0, -1, -1, 5, 1, -1, -1);
        settle();
        check_counts("early_eol", 1, 0, 0, 1, 1'b1);

        // Stray SOF at (3,2), then a clean frame
        do_reset();
        send_frame(1, 8, 4, 0, -1, -1, -1, -1, 3, 2);
        send_frame(1, 8, 4, 0, -1, -1, -1, -1, -1, -1);
        settle();
        check_counts("mid_sof", 2, 0, 1, 0, 1'b1);

        // Saturation, clear priority, mid-frame reset
        do_reset();
        send_frame(1, 8, 4, 0, -1, -1, -1, -1, -1, -1);
        settle();
        force dut.err_data_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_data_cnt_q;
        send_frame(1, 8, 4, 0, 3, 1, -1, -1, -1, -1);
        settle();
        chk("sat_err_data", {16'd0, err_data_cnt}, 32'h0000FFFF);
        chk("sat_err_any", {31'd0, err_any}, 32'd1);
        clr_err = 1'b1;
        send_frame(1, 8, 4, 0, 4, 2, -1, -1, -1, -1);
        settle();
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_data", {16'd0, err_data_cnt}, 32'd0);
        chk("clr_err_any", {31'd0, err_any}, 32'd0);
        chk("clr_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        chk("clr_locked", {31'd0, locked}, 32'd1);

        send_beat(pix(1, 0, 0, 0), 1'b1, 1'b0);
        send_beat(pix(1, 1, 0, 0), 1'b0, 1'b0);
        send_beat(16'hBEEF, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_locked", {31'd0, locked}, 32'd0);
        chk("midrst_tready", {31'd0, tready}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("midrst_err_data", {16'd0, err_data_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fd_base = fd_pulses;
        for (int i = 0; i < 3; i++) send_beat(16'($urandom), 1'b0, 1'b0);
        settle();
        chk("rehunt_locked", {31'd0, locked}, 32'd0);
        send_frame(1, 8, 4, 0, -1, -1, -1, -1, -1, -1);
        settle();
        check_counts("rehunt", 1, 0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_tpg_checker.md
# axis_tpg_checker

AXI-Stream video sink that consumes a test-pattern stream, tracks pixel, line and frame position, and recomputes the expected pixel value for the selected pattern mode. It checks SOF (tuser), EOL (tlast) and data on every accepted beat, counts frames and errors, and resynchronises on framing faults. It sits at the far end of a video pipeline, such as after 3DNR, VDMA loopback or a link, and serves as the self-check endpoint for pattern generator traffic.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel width.
- CHESS_WPOW, 4, x bit selecting chess column parity.
- CHESS_HPOW, 4, y bit selecting chess row parity.

Ports:
- m_axis_aclk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- ACTIVE_WIDTH  in  16  pixels per line (≥2).
- ACTIVE_HEIGHT  in  16  lines per frame (≥2).
- tpg_mode  in  4  expected pattern: 0 chess, 1 x ramp, 2 y ramp, 3 x+frame, 4 y+frame, 5 all-ones, others all-zeros.
- s_axis_tdata  in  DATA_WIDTH  pixel.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  sink ready.
- clr_err  in  1  synchronous clear of error counters and err_any.
- locked  out  1  high while in RUN.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_cnt  out  16  completed frames, wraps.
- err_data_cnt / err_sof_cnt / err_eol_cnt  out  16 each  saturating at 16'hFFFF.
- err_any  out  1  sticky, set by any error.

## Operation
- A beat is accepted when s_axis_tvalid and s_axis_tready are high at a rising edge. s_axis_tready never depends on s_axis_tvalid.
- Internal counters: x, y, z (16 bit).
- State machine:
  - HUNT (reset state): accepted beats are discarded until a beat carries tuser=1.
  - On that beat, latch W=ACTIVE_WIDTH, H=ACTIVE_HEIGHT, mode=tpg_mode. Treat the beat as (0,0).
  - Seed z: z=tdata for mode 3 or 4; z=0 otherwise.
  - Advance to (1,0) and go to RUN. The SOF beat itself is not checked.
- Expected data at (x,y,z), truncated to DATA_WIDTH:
  - Mode 0: all-ones if x[CHESS_WPOW]==y[CHESS_HPOW], else 0.
  - Mode 1: x.
  - Mode 2: y.
  - Mode 3: x+z.
  - Mode 4: y+z.
  - Mode 5: all-ones.
  - Other modes: 0.
- RUN checks on each accepted beat:
  - tdata≠expected: err_data_cnt++.
  - tuser≠(x==0 && y==0): err_sof_cnt++.
  - tlast≠(x==W-1): err_eol_cnt++.
- Advance rules in RUN:
  - Unexpected tuser=1 (early or mid-frame SOF): count it, relatch W/H/mode, reseed z as in HUNT, treat the beat as (0,0), next position (1,0). No data check on this beat.
  - Early tlast (tlast=1 with x<W-1): count it, next x=0, y=y+1 (y wraps to 0 and z increments if y==H-1).
  - Missing tlast at x==W-1: count it, wrap normally.
  - Normal: x++; at x==W-1 → x=0, y++; at y==H-1 → y=0, z++, frame_cnt++, frame_done pulse.
- Multiple errors on one beat all increment their counters in the same cycle.
- Error counters saturate at 16'hFFFF. err_any is set by any increment.
- clr_err zeroes all err_* counters and err_any. If an error and clr_err occur in the same cycle, clr_err wins. frame_cnt and locked are unaffected.
- ACTIVE_WIDTH, ACTIVE_HEIGHT and tpg_mode changes take effect only at the next SOF.

## Timing
- Reset values while rst_n=0:
  - s_axis_tready=0, locked=0, frame_done=0.
  - All counters 0, err_any=0, state HUNT.
- First cycle after reset release: s_axis_tready=1, subject to Configuration.
- Beat accepted at edge N:
  - Position counters update at N.
  - Compare result is registered at N.
  - err_* counters, err_any, frame_cnt and frame_done update at edge N+1 (1-cycle check latency).
- locked rises at the edge accepting the HUNT SOF beat.
- rst_n low mid-frame: all outputs return to their reset values at the next edge; the block re-enters HUNT. A pending compare is discarded.
- No beat is lost or double-counted under arbitrary tvalid gaps.

## Configuration
- Macro AXIS_TPG_CHK_THROTTLE_EN.
- Defined:
  - s_axis_tready = lfsr[0] | lfsr[1] (~75% duty).
  - 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seeded 16'hACE1 in reset, stepping every cycle out of reset.
  - Used to exercise upstream backpressure.
- Undefined: no LFSR; s_axis_tready=1 in every cycle out of reset.

## Test plan
- W=8, H=4, mode 1, clean stream, 3 frames with random tvalid gaps → frame_cnt=3, three frame_done pulses, all err_*=0, locked=1.
- Mode 3, first SOF tdata=5, 2 frames → z seeds 5; second frame beat (2,1) expects 8; err_data_cnt=0.
- Mode 0, CHESS_WPOW=CHESS_HPOW=1, W=H=4, flip tdata at (2,0) → err_data_cnt=1, err_any=1, frame still counted.
- tlast asserted at x=5 of an 8-wide line → err_eol_cnt=1; the next beat is checked as (0,y+1) with no further errors.
- tuser asserted at (3,2) mid-frame → err_sof_cnt=1; checking resumes from (0,0); the following full frame is clean.
- Force err_data_cnt to 16'hFFFF, inject another error together with clr_err → counter reads 0, err_any=0; reset mid-frame → locked=0, block re-hunts on the next SOF.
